psum_collector: RTL

- Sits directly downstream of the last PE_reg stage in the SD4 MAC systolic chain.
- Consumes the 16-bit partial sum and 5-bit exponent bias leaving the array.
- Accumulates NUM_PASS consecutive psums into one wide result per output pixel.
- Buffers finished results in a small FIFO with a valid/ready interface to the writeback logic.

---
 rtl/psum_collector.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/psum_collector.sv
// psum_collector: accumulates NUM_PASS consecutive partial sums leaving the
// last PE_reg stage of the SD4 MAC systolic chain into one wide result per
// output pixel, then queues finished results in a small FIFO towards the
// writeback logic (valid/ready on both sides).
//
// Optional build macro: PSUM_COLLECTOR_SAT_EN
//   defined   - every add saturates to the signed ACC_W range; overflow is a
//               sticky flag raised on any saturation.
//   undefined - two's-complement wrap-around; overflow is tied low.
module psum_collector #(
  parameter int PSUM_W     = 16,
  parameter int ACC_W      = 24,
  parameter int NUM_PASS   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psum_valid,
  output logic              psum_ready,
  input  logic [PSUM_W-1:0] psum_in,
  input  logic [4:0]        exp_bias_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [4:0]        out_exp,
  output logic              out_partial,
  output logic              exp_err,
  output logic              overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PC_W  = $clog2(NUM_PASS + 1);

  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [PC_W-1:0]  PASS_LAST = PC_W'(NUM_PASS);

  typedef enum logic {
    S_IDLE,
    S_ACCUM
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [ACC_W-1:0]   r_acc;
  logic [PC_W-1:0]    r_pass_cnt;
  logic [4:0]         r_exp_lat;
  logic               r_exp_err;

  logic [ACC_W-1:0]   r_mem_data [FIFO_DEPTH];
  logic [4:0]         r_mem_exp  [FIFO_DEPTH];
  logic               r_mem_part [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_ready;
  logic               w_accept;
  logic               w_flush;
  logic               w_in_group;
  logic [ACC_W-1:0]   w_base;
  logic [ACC_W-1:0]   w_sum;
  logic               w_sat;
  logic [PC_W-1:0]    w_cnt_next;
  logic               w_close;
  logic               w_push;
  logic               w_pop;
  logic [ACC_W-1:0]   w_push_data;
  logic [4:0]         w_push_exp;
  logic               w_push_partial;

  // Handshake qualifiers; flush is only honoured while the FIFO has room.
  always_comb begin
    w_ready    = (r_count != FIFO_FULL);
    w_accept   = psum_valid && w_ready;
    w_flush    = flush && w_ready;
    w_in_group = (r_state == S_ACCUM);
    w_pop      = (r_count != '0) && out_ready;
  end

`ifdef PSUM_COLLECTOR_SAT_EN
  logic [ACC_W:0] w_wide;

  // Saturating add: one guard bit exposes signed overflow of the ACC_W sum.
  always_comb begin
    w_base = w_in_group ? r_acc : '0;
    w_wide = (ACC_W+1)'($signed(w_base)) + (ACC_W+1)'($signed(psum_in));
    w_sat  = (w_wide[ACC_W] != w_wide[ACC_W-1]);
    if (!w_sat)
      w_sum = w_wide[ACC_W-1:0];
    else if (w_wide[ACC_W])
      w_sum = {1'b1, {(ACC_W-1){1'b0}}};
    else
      w_sum = {1'b0, {(ACC_W-1){1'b1}}};
  end

  logic r_overflow;

  // Sticky saturation flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)
      r_overflow <= 1'b0;
    else if (w_accept && w_sat)
      r_overflow <= 1'b1;
  end

  assign overflow = r_overflow;
`else
  // Wrapping add at ACC_W bits after sign extension.
  always_comb begin
    w_base = w_in_group ? r_acc : '0;
    w_sum  = w_base + ACC_W'($signed(psum_in));
    w_sat  = 1'b0;
  end

  assign overflow = 1'b0;
`endif

  // Group bookkeeping: decide whether this edge closes a group and what is
  // pushed. An IDLE accept starts from zero, so the same adder covers it.
  always_comb begin
    w_cnt_next     = (w_in_group ? r_pass_cnt : '0) + PC_W'(1);
    w_close        = w_accept && (w_cnt_next == PASS_LAST);
    w_push         = w_close || (w_flush && (w_accept || w_in_group));
    w_push_data    = w_accept ? w_sum : r_acc;
    w_push_exp     = w_in_group ? r_exp_lat : exp_bias_in;
    w_push_partial = !w_close;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  // FSM next state: any push ends the group, a plain accept keeps/opens one.
  always_comb begin
    w_state_next = r_state;
    if (w_push)
      w_state_next = S_IDLE;
    else if (w_accept)
      w_state_next = S_ACCUM;
  end

  // Accumulator, pass counter and latched exponent of the open group.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_pass_cnt <= '0;
      r_exp_lat  <= '0;
    end else if (w_push) begin
      r_acc      <= '0;
      r_pass_cnt <= '0;
    end else if (w_accept) begin
      r_acc      <= w_sum;
      r_pass_cnt <= w_cnt_next;
      if (!w_in_group)
        r_exp_lat <= exp_bias_in;
    end
  end

  // Sticky exponent mismatch inside a group; the sample is still summed.
  always_ff @(posedge clk) begin
    if (rst)
      r_exp_err <= 1'b0;
    else if (w_accept && w_in_group && (exp_bias_in != r_exp_lat))
      r_exp_err <= 1'b1;
  end

  // Result FIFO storage; entries are only ever read while count != 0.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_push_data;
      r_mem_exp[r_wr_ptr]  <= w_push_exp;
      r_mem_part[r_wr_ptr] <= w_push_partial;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head outputs are gated so that an empty FIFO presents zeros.
  always_comb begin
    psum_ready  = w_ready;
    out_valid   = (r_count != '0);
    out_data    = out_valid ? r_mem_data[r_rd_ptr] : '0;
    out_exp     = out_valid ? r_mem_exp[r_rd_ptr]  : '0;
    out_partial = out_valid ? r_mem_part[r_rd_ptr] : 1'b0;
    exp_err     = r_exp_err;
  end

endmodule
